// File: rtl/fir_pkg.sv
// Shared fixed-point constants, sizing helpers and state encoding for the FIR chain
// (filtro_fir and fir_decimator).
package fir_pkg;

    localparam int NB_S87       = 8;
    localparam int NBF_S87      = 7;
    localparam int DEF_LOG2_DEC = 2;

    function automatic int calc_nb_acc(input int nb_in, input int log2_dec);
        return nb_in + log2_dec;
    endfunction

    // Total right shift: divide by DEC and drop the surplus fraction bits.
    function automatic int calc_sh(input int log2_dec, input int nbf_in, input int nbf_out);
        return log2_dec + nbf_in - nbf_out;
    endfunction

    localparam int NB_ACC = calc_nb_acc(NB_S87, DEF_LOG2_DEC);
    localparam int SH     = calc_sh(DEF_LOG2_DEC, NBF_S87, NBF_S87);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } dec_state_t;

endpackage

// File: rtl/fir_decimator_if.sv
// Sample-stream bundle between the FIR output and the decimator.
interface fir_decimator_if #(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 8
);
    logic                        i_en;
    logic signed [NB_INPUT-1:0]  i_is_data;
    logic signed [NB_OUTPUT-1:0] o_os_data;
    logic                        o_valid;
    logic                        o_sat;

    modport master (output i_en, i_is_data, input o_os_data, o_valid, o_sat);
    modport slave  (input i_en, i_is_data, output o_os_data, o_valid, o_sat);
endinterface

// File: rtl/fir_decimator_sat_round.sv
// Combinational round-half-up by SH bits followed by saturation to NB_OUT bits;
// also used for filtro_fir output requantization.
module sat_round #(
    parameter int NB_IN  = 10,
    parameter int SH     = 2,
    parameter int NB_OUT = 8
) (
    input  logic signed [NB_IN-1:0]  i_data,
    output logic signed [NB_OUT-1:0] o_data,
    output logic                     o_ovf
);
    localparam int NB_W = NB_IN + 1;
    localparam logic signed [NB_W-1:0] HALF  = NB_W'(1) << (SH - 1);
    localparam logic signed [NB_W-1:0] MAX_V = NB_W'((1 << (NB_OUT - 1)) - 1);
    localparam logic signed [NB_W-1:0] MIN_V = ~MAX_V;

    // One guard bit so adding the half LSB can never wrap.
    logic signed [NB_W-1:0] rnd_d;
    logic signed [NB_W-1:0] shr_d;

    always_comb begin
        rnd_d = {i_data[NB_IN-1], i_data} + HALF;
        shr_d = rnd_d >>> SH;
        o_ovf = 1'b0;
        if (shr_d > MAX_V) begin
            o_data = MAX_V[NB_OUT-1:0];
            o_ovf  = 1'b1;
        end else if (shr_d < MIN_V) begin
            o_data = MIN_V[NB_OUT-1:0];
            o_ovf  = 1'b1;
        end else begin
            o_data = shr_d[NB_OUT-1:0];
        end
    end
endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages blocks of 2^LOG2_DEC enabled samples and
// emits one rounded, saturated sample per block; the first block after reset is discarded.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int NB_INPUT   = 8,
    parameter int NBF_INPUT  = 7,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 7,
    parameter int LOG2_DEC   = 2
) (
    input  logic           clk,
    input  logic           i_rst_n,
    input  logic           i_srst,
    fir_decimator_if.slave bus
);
    localparam int ACC_W = calc_nb_acc(NB_INPUT, LOG2_DEC);
    localparam int SHIFT = calc_sh(LOG2_DEC, NBF_INPUT, NBF_OUTPUT);
    localparam logic [LOG2_DEC-1:0] CNT_LAST = '1;

    logic [LOG2_DEC-1:0]         cnt_q;
    logic signed [ACC_W-1:0]     acc_q;
    dec_state_t                  state_q;
    logic signed [NB_OUTPUT-1:0] data_q;
    logic                        valid_q;
    logic                        sat_q;

    logic                        dump_d;
    logic signed [ACC_W-1:0]     sum_d;
    logic signed [NB_OUTPUT-1:0] rq_d;
    logic                        ovf_d;

    // The dump sum includes the sample arriving on the dump cycle.
    assign dump_d = bus.i_en && (cnt_q == CNT_LAST);
    assign sum_d  = acc_q + {{LOG2_DEC{bus.i_is_data[NB_INPUT-1]}}, bus.i_is_data};

    sat_round #(
        .NB_IN (ACC_W),
        .SH    (SHIFT),
        .NB_OUT(NB_OUTPUT)
    ) u_sat_round (
        .i_data(sum_d),
        .o_data(rq_d),
        .o_ovf (ovf_d)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= PRIME;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (i_srst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= PRIME;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.i_en) begin
                cnt_q <= cnt_q + 1'b1;
                if (dump_d) begin
                    acc_q <= '0;
                    // PRIME swallows the pipeline-fill block of the upstream FIR.
                    if (state_q == PRIME) begin
                        state_q <= RUN;
                    end else begin
                        data_q  <= rq_d;
                        valid_q <= 1'b1;
                        sat_q   <= sat_q | ovf_d;
                    end
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign bus.o_os_data = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_sat     = sat_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: S(8,7) and S(7,6) output instances fed the same stream,
// checked every cycle against a block-average model plus directed literal checks.
module tb_fir_decimator;
    localparam int DEC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic srst = 1'b0;
    logic en = 1'b0;
    logic signed [7:0] din = '0;

    always #5 clk = ~clk;

    fir_decimator_if #(.NB_INPUT(8), .NB_OUTPUT(8)) bus_a ();
    fir_decimator_if #(.NB_INPUT(8), .NB_OUTPUT(7)) bus_b ();

    assign bus_a.i_en      = en;
    assign bus_a.i_is_data = din;
    assign bus_b.i_en      = en;
    assign bus_b.i_is_data = din;

    fir_decimator #(
        .NB_INPUT(8), .NBF_INPUT(7), .NB_OUTPUT(8), .NBF_OUTPUT(7), .LOG2_DEC(2)
    ) dut_a (
        .clk(clk), .i_rst_n(rst_n), .i_srst(srst), .bus(bus_a)
    );

    fir_decimator #(
        .NB_INPUT(8), .NBF_INPUT(7), .NB_OUTPUT(7), .NBF_OUTPUT(6), .LOG2_DEC(2)
    ) dut_b (
        .clk(clk), .i_rst_n(rst_n), .i_srst(srst), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: mean of the block, rounded half-up to the output LSB, clamped.
    function automatic void requant(input int sum, input int sh, input int nbout,
                                    output int val, output bit ovf);
        int d, num, q, mx, mn;
        d   = 1 << sh;
        num = sum + d / 2;
        if (num >= 0) q = num / d;
        else          q = -((-num + d - 1) / d);
        mx  = (1 << (nbout - 1)) - 1;
        mn  = -(1 << (nbout - 1));
        ovf = 1'b0;
        val = q;
        if (q > mx) begin val = mx; ovf = 1'b1; end
        if (q < mn) begin val = mn; ovf = 1'b1; end
    endfunction

    int m_data[2];
    bit m_valid[2];
    bit m_sat[2];
    bit m_primed;
    int blk[$];
    int sh_of[2] = '{2, 3};
    int nb_of[2] = '{8, 7};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || srst) begin
            m_data  = '{0, 0};
            m_valid = '{0, 0};
            m_sat   = '{0, 0};
            m_primed = 1'b0;
            blk.delete();
        end else begin
            m_valid = '{0, 0};
            if (en) begin
                blk.push_back(int'(din));
                if (blk.size() == DEC) begin
                    int s;
                    s = 0;
                    foreach (blk[i]) s += blk[i];
                    if (m_primed) begin
                        for (int k = 0; k < 2; k++) begin
                            int v;
                            bit o;
                            requant(s, sh_of[k], nb_of[k], v, o);
                            m_data[k]  = v;
                            m_valid[k] = 1'b1;
                            if (o) m_sat[k] = 1'b1;
                        end
                    end
                    m_primed = 1'b1;
                    blk.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_valid", int'(bus_a.o_valid), int'(m_valid[0]));
            chk("a_data",  int'(bus_a.o_os_data), m_data[0]);
            chk("a_sat",   int'(bus_a.o_sat), int'(m_sat[0]));
            chk("b_valid", int'(bus_b.o_valid), int'(m_valid[1]));
            chk("b_data",  int'(bus_b.o_os_data), m_data[1]);
            chk("b_sat",   int'(bus_b.o_sat), int'(m_sat[1]));
        end
    end

    task automatic put(input int d);
        @(negedge clk);
        en  = 1'b1;
        din = 8'(d);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic block4(input int d0, input int d1, input int d2, input int d3);
        put(d0); put(d1); put(d2); put(d3);
    endtask

    // One cycle after the last sample of a block: check strobe and both outputs.
    task automatic look(input string nm, input int v, input int da, input int db);
        @(negedge clk);
        en = 1'b0;
        chk({nm, "_valid"}, int'(bus_a.o_valid), v);
        chk({nm, "_data_a"}, int'(bus_a.o_os_data), da);
        chk({nm, "_data_b"}, int'(bus_b.o_os_data), db);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(bus_a.o_valid), 0);
        chk("rst_data",  int'(bus_a.o_os_data), 0);
        chk("rst_sat",   int'(bus_b.o_sat), 0);
        rst_n = 1'b1;

        block4(8'h40, 8'h40, 8'h40, 8'h40);
        look("prime", 0, 0, 0);
        block4(8'h40, 8'h40, 8'h40, 8'h40);
        look("const40", 1, 64, 32);

        block4(8'h10, 8'h20, 8'h30, 8'h41);
        look("mix161", 1, 40, 20);
        block4(2, 2, 2, 3);
        look("sum9", 1, 2, 1);
        block4(1, 2, 2, 1);
        look("half6", 1, 2, 1);

        block4(8'h80, 8'h80, 8'h80, 8'h80);
        look("neg_fs", 1, -128, -64);
        chk("neg_fs_sat_a", int'(bus_a.o_sat), 0);
        block4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        look("pos_fs", 1, 127, 63);
        chk("pos_fs_sat_a", int'(bus_a.o_sat), 0);
        chk("pos_fs_sat_b", int'(bus_b.o_sat), 1);
        block4(0, 0, 0, 0);
        look("zero", 1, 0, 0);
        chk("sticky_sat_b", int'(bus_b.o_sat), 1);

        for (int i = 0; i < 4; i++) begin
            put(8'h20);
            if (i < 3) idle();
        end
        look("toggle_en", 1, 32, 16);

        put(8'h10); put(8'h10); put(8'h10);
        idle(); idle();
        chk("hold_no_dump", int'(bus_a.o_valid), 0);
        put(8'h10);
        look("late_dump", 1, 16, 8);

        put(8'h50); put(8'h50);
        @(negedge clk);
        srst = 1'b1;
        en   = 1'b1;
        din  = 8'h70;
        @(negedge clk);
        srst = 1'b0;
        en   = 1'b0;
        chk("srst_valid", int'(bus_a.o_valid), 0);
        chk("srst_data",  int'(bus_a.o_os_data), 0);
        chk("srst_sat_b", int'(bus_b.o_sat), 0);
        block4(8'h30, 8'h30, 8'h30, 8'h30);
        look("srst_prime", 0, 0, 0);
        block4(8'h30, 8'h30, 8'h30, 8'h30);
        look("srst_run", 1, 48, 24);

        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      din = 8'h7F;
            else if (r == 1) din = 8'h80;
            else             din = 8'($urandom);
            srst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        en   = 1'b0;
        srst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
